cfg_chain_driver: RTL

- Transmit end of the latch-based configuration shift chain used by the LUT4c-style BELs.
- Accepts parallel configuration words over a valid/ready stream and serialises them MSB-first onto the chain data input.
- Generates the two non-overlapping latch-enable phases: phase A drives the even-latch enables, phase B drives the odd-latch enables.
- Sits between the fabric configuration port and the first tile's chain input.

---
 rtl/cfg_chain_pkg.sv | 38 +++
 rtl/cfg_phase_gen.sv | 81 ++++++++
 rtl/cfg_chain_driver.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cfg_chain_pkg.sv
// Shared types and constants for the configuration chain driver and its phase timer.
// The readback capture path is enabled by defining CFG_CHAIN_READBACK_EN.
package cfg_chain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SETUP = 3'd2,
        ST_PH_A  = 3'd3,
        ST_GAP_A = 3'd4,
        ST_PH_B  = 3'd5,
        ST_GAP_B = 3'd6,
        ST_DONE  = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        SEG_IDLE = 3'd0,
        SEG_A    = 3'd1,
        SEG_GA   = 3'd2,
        SEG_B    = 3'd3,
        SEG_GB   = 3'd4
    } seg_t;

    // Defaults shared with the tile-side latch timing documentation.
    localparam int DEF_WORD_W    = 32;
    localparam int DEF_CHAIN_LEN = 144;
    localparam int DEF_PHASE_CYC = 2;
    localparam int DEF_GAP_CYC   = 1;

    // Bits needed to hold the values 0..max_val inclusive.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int DEF_STEP_W = cnt_w(DEF_CHAIN_LEN);
    localparam int DEF_BIT_W  = cnt_w(DEF_WORD_W);

endpackage

// File: rtl/cfg_phase_gen.sv
// Phase-pulse timer: on i_start produces phase_a, gap, phase_b, gap, with a
// combinational end-of-segment flag so the parent FSM can track it in lockstep.
module cfg_phase_gen
    import cfg_chain_pkg::*;
#(
    parameter int PHASE_CYC = DEF_PHASE_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC
) (
    input  logic CLK,
    input  logic resetn,
    input  logic i_start,
    output logic o_phase_a,
    output logic o_phase_b,
    output logic o_seg_last,
    output logic o_step_done
);

    localparam int CNT_W = cnt_w((PHASE_CYC > GAP_CYC) ? PHASE_CYC : GAP_CYC);
    localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(PHASE_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);

    seg_t             r_seg, w_seg_nx;
    logic [CNT_W-1:0] r_cnt, w_cnt_nx;
    logic             w_seg_last;
    logic             r_phase_a, r_phase_b;

    // Last cycle of the active segment
    always_comb begin
        w_seg_last = 1'b0;
        case (r_seg)
            SEG_A, SEG_B:   w_seg_last = (r_cnt == PH_LAST);
            SEG_GA, SEG_GB: w_seg_last = (r_cnt == GAP_LAST);
            default:        w_seg_last = 1'b0;
        endcase
    end

    // Segment sequencing and in-segment cycle counting
    always_comb begin
        w_seg_nx = r_seg;
        w_cnt_nx = r_cnt + CNT_W'(1);
        if (r_seg == SEG_IDLE) begin
            w_cnt_nx = '0;
            if (i_start) begin
                w_seg_nx = SEG_A;
            end else begin
                w_seg_nx = SEG_IDLE;
            end
        end else if (w_seg_last) begin
            w_cnt_nx = '0;
            case (r_seg)
                SEG_A:   w_seg_nx = SEG_GA;
                SEG_GA:  w_seg_nx = SEG_B;
                SEG_B:   w_seg_nx = SEG_GB;
                default: w_seg_nx = SEG_IDLE;
            endcase
        end else begin
            w_seg_nx = r_seg;
        end
    end

    // Enables come straight from flops so they drop the instant reset asserts
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_seg     <= SEG_IDLE;
            r_cnt     <= '0;
            r_phase_a <= 1'b0;
            r_phase_b <= 1'b0;
        end else begin
            r_seg     <= w_seg_nx;
            r_cnt     <= w_cnt_nx;
            r_phase_a <= (w_seg_nx == SEG_A);
            r_phase_b <= (w_seg_nx == SEG_B);
        end
    end

    assign o_phase_a   = r_phase_a;
    assign o_phase_b   = r_phase_b;
    assign o_seg_last  = w_seg_last;
    assign o_step_done = w_seg_last && (r_seg == SEG_GB);

endmodule

// File: rtl/cfg_chain_driver.sv
// Serialises configuration words MSB-first into the latch chain with two
// non-overlapping enables. Define CFG_CHAIN_READBACK_EN to add tail readback.
module cfg_chain_driver
    import cfg_chain_pkg::*;
#(
    parameter int WORD_W    = DEF_WORD_W,
    parameter int CHAIN_LEN = DEF_CHAIN_LEN,
    parameter int PHASE_CYC = DEF_PHASE_CYC,
    parameter int GAP_CYC   = DEF_GAP_CYC
) (
    input  logic              CLK,
    input  logic              resetn,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              cfg_data,
    output logic              cfg_phase_a,
    output logic              cfg_phase_b,
    output logic              busy,
    output logic              frame_done
`ifdef CFG_CHAIN_READBACK_EN
    ,
    input  logic              rb_in,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
`endif
);

    localparam int STEP_W = cnt_w(CHAIN_LEN);
    localparam int BIT_W  = cnt_w(WORD_W);

    state_t              r_state, w_state_nx;
    logic [WORD_W-1:0]   r_shift, w_shift_nx;
    logic [STEP_W-1:0]   r_step, w_step_nx;
    logic [BIT_W-1:0]    r_bit, w_bit_nx;
    logic                r_cfg_data, w_cfg_data_nx;
    logic                r_ready, r_busy, r_done;
    logic                w_accept, w_start, w_seg_last, w_step_done;

    assign w_accept = s_valid && r_ready && ((r_state == ST_IDLE) || (r_state == ST_LOAD));
    assign w_start  = (r_state == ST_SETUP);

    cfg_phase_gen #(
        .PHASE_CYC (PHASE_CYC),
        .GAP_CYC   (GAP_CYC)
    ) u_phase_gen (
        .CLK         (CLK),
        .resetn      (resetn),
        .i_start     (w_start),
        .o_phase_a   (cfg_phase_a),
        .o_phase_b   (cfg_phase_b),
        .o_seg_last  (w_seg_last),
        .o_step_done (w_step_done)
    );

    // Frame sequencing; phase states follow the timer segment by segment
    always_comb begin
        w_state_nx    = r_state;
        w_shift_nx    = r_shift;
        w_step_nx     = r_step;
        w_bit_nx      = r_bit;
        w_cfg_data_nx = r_cfg_data;
        case (r_state)
            ST_IDLE, ST_LOAD: begin
                if (w_accept) begin
                    w_shift_nx    = s_data;
                    w_bit_nx      = '0;
                    w_cfg_data_nx = s_data[WORD_W-1];
                    w_state_nx    = ST_SETUP;
                    if (r_state == ST_IDLE) begin
                        w_step_nx = '0;
                    end else begin
                        w_step_nx = r_step;
                    end
                end else begin
                    w_state_nx = r_state;
                end
            end
            ST_SETUP: w_state_nx = ST_PH_A;
            ST_PH_A:  w_state_nx = w_seg_last ? ST_GAP_A : ST_PH_A;
            ST_GAP_A: w_state_nx = w_seg_last ? ST_PH_B : ST_GAP_A;
            ST_PH_B:  w_state_nx = w_seg_last ? ST_GAP_B : ST_PH_B;
            ST_GAP_B: begin
                if (w_step_done) begin
                    w_step_nx = r_step + STEP_W'(1);
                    w_bit_nx  = r_bit + BIT_W'(1);
                    if (w_step_nx == STEP_W'(CHAIN_LEN)) begin
                        w_state_nx = ST_DONE;
                    end else if (w_bit_nx == BIT_W'(WORD_W)) begin
                        w_state_nx = ST_LOAD;
                    end else begin
                        w_shift_nx    = r_shift << 1;
                        w_cfg_data_nx = w_shift_nx[WORD_W-1];
                        w_state_nx    = ST_SETUP;
                    end
                end else begin
                    w_state_nx = ST_GAP_B;
                end
            end
            ST_DONE:  w_state_nx = ST_IDLE;
            default:  w_state_nx = ST_IDLE;
        endcase
    end

    // State, datapath and outputs registered from the next state
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_shift    <= '0;
            r_step     <= '0;
            r_bit      <= '0;
            r_cfg_data <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_shift    <= w_shift_nx;
            r_step     <= w_step_nx;
            r_bit      <= w_bit_nx;
            r_cfg_data <= w_cfg_data_nx;
            r_ready    <= (w_state_nx == ST_IDLE) || (w_state_nx == ST_LOAD);
            r_busy     <= (w_state_nx != ST_IDLE) && (w_state_nx != ST_DONE);
            r_done     <= (w_state_nx == ST_DONE);
        end
    end

    assign s_ready    = r_ready;
    assign cfg_data   = r_cfg_data;
    assign busy       = r_busy;
    assign frame_done = r_done;

`ifdef CFG_CHAIN_READBACK_EN
    logic [WORD_W-1:0] r_cap, r_rb_data, w_cap_nx;
    logic [BIT_W-1:0]  r_rb_cnt, w_rb_cnt_nx;
    logic              r_rb_valid;

    assign w_cap_nx    = (r_cap << 1) | WORD_W'(rb_in);
    assign w_rb_cnt_nx = r_rb_cnt + BIT_W'(1);

    // One tail sample per completed step; flush on a full word or, left-aligned, at frame end
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            r_cap      <= '0;
            r_rb_cnt   <= '0;
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            if (w_step_done) begin
                if (w_rb_cnt_nx == BIT_W'(WORD_W)) begin
                    r_rb_data  <= w_cap_nx;
                    r_rb_valid <= 1'b1;
                    r_cap      <= '0;
                    r_rb_cnt   <= '0;
                end else if (w_state_nx == ST_DONE) begin
                    r_rb_data  <= w_cap_nx << (BIT_W'(WORD_W) - w_rb_cnt_nx);
                    r_rb_valid <= 1'b1;
                    r_cap      <= '0;
                    r_rb_cnt   <= '0;
                end else begin
                    r_cap    <= w_cap_nx;
                    r_rb_cnt <= w_rb_cnt_nx;
                end
            end
        end
    end

    assign rb_data  = r_rb_data;
    assign rb_valid = r_rb_valid;
`endif

endmodule
